// File: rtl/relu_backward_mask.sv
// ----------------------------------------------------------------------------
// relu_backward_mask
//   Backward-direction companion of the layer-1 ReLU stage.
//   Capture phase: streams the CHANNELS x HEIGHT x WIDTH pre-activation map in
//   raster order and stores one derivative bit per element (1 = passed ReLU,
//   i.e. value >= 0).
//   Backward phase: streams the matching gradient map and emits each gradient
//   gated by its stored mask bit, one-cycle latency, full throughput.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous abort back to capture phase
//   fwd_valid/ready   forward element stream, fwd_data signed BITWIDTH
//   grad_valid/ready  incoming gradient stream, grad_data signed BITWIDTH
//   gout_valid/ready  masked gradient stream, gout_data, gout_last on final
//   mask_ready        mask complete, backward pass open
//   done              one-cycle pulse after final gout handshake
// ----------------------------------------------------------------------------
module relu_backward_mask #(
   parameter int BITWIDTH = 32,
   parameter int CHANNELS = 2,
   parameter int HEIGHT   = 28,
   parameter int WIDTH    = 28
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                fwd_valid,
   output logic                fwd_ready,
   input  logic [BITWIDTH-1:0] fwd_data,
   input  logic                grad_valid,
   output logic                grad_ready,
   input  logic [BITWIDTH-1:0] grad_data,
   output logic                gout_valid,
   input  logic                gout_ready,
   output logic [BITWIDTH-1:0] gout_data,
   output logic                gout_last,
   output logic                mask_ready,
   output logic                done
);

   localparam int TOTAL = CHANNELS * HEIGHT * WIDTH;
   localparam int CNT_W = $clog2(TOTAL);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      S_CAPTURE  = 2'd0,
      S_BACKWARD = 2'd1,
      S_DRAIN    = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [TOTAL-1:0]    r_mask;
   logic                r_gout_valid;
   logic [BITWIDTH-1:0] r_gout_data;
   logic                r_gout_last;
   logic                r_mask_ready;
   logic                r_done;

   logic w_fwd_acc;
   logic w_grad_acc;
   logic w_gout_hs;
   logic w_fwd_nonneg;
   logic w_cnt_last;

   // clear masks both readies so no handshake can land on the abort edge.
   assign fwd_ready  = !clear && (r_state == S_CAPTURE);
   assign grad_ready = !clear && (r_state == S_BACKWARD) &&
                       (!r_gout_valid || gout_ready);

   assign w_fwd_acc  = fwd_valid && fwd_ready;
   assign w_grad_acc = grad_valid && grad_ready;
   assign w_gout_hs  = r_gout_valid && gout_ready;

   // Zero passes ReLU, so only a set sign bit clears the mask.
   assign w_fwd_nonneg = !($signed(fwd_data) < 0);
   assign w_cnt_last   = (r_cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_CAPTURE;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_gout_valid <= 1'b0;
         r_gout_data  <= '0;
         r_gout_last  <= 1'b0;
         r_mask_ready <= 1'b0;
         r_done       <= 1'b0;
      end else if (clear) begin
         r_state      <= S_CAPTURE;
         r_cnt        <= '0;
         r_gout_valid <= 1'b0;
         r_gout_last  <= 1'b0;
         r_mask_ready <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_CAPTURE: begin
               if (w_fwd_acc) begin
                  r_mask[r_cnt] <= w_fwd_nonneg;
                  if (w_cnt_last) begin
                     r_cnt        <= '0;
                     r_mask_ready <= 1'b1;
                     r_state      <= S_BACKWARD;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_BACKWARD: begin
               if (w_grad_acc) begin
                  r_gout_data  <= r_mask[r_cnt] ? grad_data : '0;
                  r_gout_valid <= 1'b1;
                  r_gout_last  <= w_cnt_last;
                  if (w_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else if (w_gout_hs) begin
                  r_gout_valid <= 1'b0;
                  r_gout_last  <= 1'b0;
               end
            end
            S_DRAIN: begin
               // Only the final element is outstanding here.
               if (w_gout_hs) begin
                  r_gout_valid <= 1'b0;
                  r_gout_last  <= 1'b0;
                  r_mask_ready <= 1'b0;
                  r_done       <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= S_CAPTURE;
               end
            end
            default: begin
               r_state <= S_CAPTURE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign gout_valid = r_gout_valid;
   assign gout_data  = r_gout_data;
   assign gout_last  = r_gout_last;
   assign mask_ready = r_mask_ready;
   assign done       = r_done;

endmodule

// File: tb/tb_relu_backward_mask.sv
// ----------------------------------------------------------------------------
// tb_relu_backward_mask
//   Randomised passes against a reference model: the expected output of
//   element i is grad[i] when fwd[i] >= 0 (signed) and 0 otherwise. Stream
//   positions are tracked as plain counters of accepted/emitted elements.
// ----------------------------------------------------------------------------
module tb_relu_backward_mask;

   localparam int BW    = 32;
   localparam int TOTAL = 2 * 28 * 28;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          fwd_valid = 1'b0;
   logic          fwd_ready;
   logic [BW-1:0] fwd_data = '0;
   logic          grad_valid = 1'b0;
   logic          grad_ready;
   logic [BW-1:0] grad_data = '0;
   logic          gout_valid;
   logic          gout_ready = 1'b0;
   logic [BW-1:0] gout_data;
   logic          gout_last;
   logic          mask_ready;
   logic          done;

   relu_backward_mask #(.BITWIDTH(BW), .CHANNELS(2), .HEIGHT(28), .WIDTH(28)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
      .gout_valid(gout_valid), .gout_ready(gout_ready), .gout_data(gout_data),
      .gout_last(gout_last), .mask_ready(mask_ready), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [BW-1:0] fwd_vals  [TOTAL];
   logic [BW-1:0] grad_vals [TOTAL];
   logic [BW-1:0] got       [TOTAL];
   int  fi, gi, oi;
   bit  done_exp = 1'b0;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] ref_out(input int i);
      return ($signed(fwd_vals[i]) >= 0) ? grad_vals[i] : '0;
   endfunction

   // bp: 0 always ready, 1 stall 5 at idx 100 then toggle, 2 random
   task automatic run_pass(input int bp, input bit gaps, input int clr_at, input int rst_at);
      int  cyc   = 0;
      int  stall = 0;
      bit  fin   = 1'b0;
      bit  f_acc, g_acc, o_hs;
      fi = 0; gi = 0; oi = 0;
      while (!fin) begin
         @(posedge clk); #1;
         cyc++;
         fwd_valid  = (fi < TOTAL) && !(gaps && (cyc % 3 == 0));
         fwd_data   = (fi < TOTAL) ? fwd_vals[fi] : '0;
         grad_valid = (gi < TOTAL);
         grad_data  = (gi < TOTAL) ? grad_vals[gi] : '0;
         case (bp)
            0: gout_ready = 1'b1;
            1: begin
               if (oi == 100 && stall < 5) begin
                  gout_ready = 1'b0;
                  stall++;
               end else if (oi >= 100) gout_ready = cyc[0];
               else gout_ready = 1'b1;
            end
            default: gout_ready = ($urandom_range(0, 3) != 0);
         endcase
         clear = (clr_at >= 0) && (fi == TOTAL) && (oi == clr_at);
         @(negedge clk);
         chk("done", {31'b0, done}, {31'b0, done_exp});
         done_exp = 1'b0;
         chk("gout_valid", {31'b0, gout_valid}, {31'b0, gi > oi});
         chk("mask_ready", {31'b0, mask_ready}, {31'b0, (fi == TOTAL) && (oi < TOTAL)});
         chk("fwd_ready", {31'b0, fwd_ready}, {31'b0, (fi < TOTAL) && !clear});
         chk("grad_ready", {31'b0, grad_ready},
             {31'b0, (fi == TOTAL) && (gi < TOTAL) && !clear && (gi == oi || gout_ready)});
         if (gi > oi) begin
            chk($sformatf("gout_data[%0d]", oi), gout_data, ref_out(oi));
            chk($sformatf("gout_last[%0d]", oi), {31'b0, gout_last}, {31'b0, oi == TOTAL - 1});
         end
         if (clear) begin
            @(posedge clk); #1;
            clear = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
            @(negedge clk);
            chk("clr_gout_valid", {31'b0, gout_valid}, 32'd0);
            chk("clr_mask_ready", {31'b0, mask_ready}, 32'd0);
            chk("clr_fwd_ready", {31'b0, fwd_ready}, 32'd1);
            chk("clr_done", {31'b0, done}, 32'd0);
            fin = 1'b1;
         end else begin
            f_acc = fwd_valid && (fi < TOTAL);
            g_acc = grad_valid && (fi == TOTAL) && (gi < TOTAL) && (gi == oi || gout_ready);
            o_hs  = (gi > oi) && gout_ready;
            if (o_hs) begin
               got[oi] = gout_data;
               oi++;
               if (oi == TOTAL) begin
                  done_exp = 1'b1;
                  fin = 1'b1;
               end
            end
            if (g_acc) gi++;
            if (f_acc) fi++;
            if (rst_at >= 0 && fi == rst_at) begin
               #2 rst_n = 1'b0;
               #1;
               chk("rst_fwd_ready", {31'b0, fwd_ready}, 32'd1);
               chk("rst_grad_ready", {31'b0, grad_ready}, 32'd0);
               chk("rst_gout_valid", {31'b0, gout_valid}, 32'd0);
               chk("rst_mask_ready", {31'b0, mask_ready}, 32'd0);
               chk("rst_done", {31'b0, done}, 32'd0);
               @(posedge clk); #1;
               rst_n = 1'b1;
               fwd_valid = 1'b0; grad_valid = 1'b0;
               done_exp = 1'b0;
               fin = 1'b1;
            end
         end
         if (cyc > 20000) begin
            chk("timeout", 32'd1, 32'd0);
            fin = 1'b1;
         end
      end
   endtask

   task automatic fill_random(input bit all_neg, input bit sat_grad);
      for (int i = 0; i < TOTAL; i++) begin
         fwd_vals[i]  = $urandom();
         if (all_neg) fwd_vals[i][BW-1] = 1'b1;
         grad_vals[i] = sat_grad ? 32'h7FFF_FFFF : $urandom();
      end
   endtask

   initial begin
      int nz;
      // reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("init_fwd_ready", {31'b0, fwd_ready}, 32'd1);
      chk("init_grad_ready", {31'b0, grad_ready}, 32'd0);
      chk("init_gout_valid", {31'b0, gout_valid}, 32'd0);
      chk("init_mask_ready", {31'b0, mask_ready}, 32'd0);
      chk("init_done", {31'b0, done}, 32'd0);

      // directed boundary pass
      for (int i = 0; i < TOTAL; i++) begin
         fwd_vals[i]  = 32'h0000_0005;
         grad_vals[i] = i + 1;
      end
      fwd_vals[0]       = 32'hFFFF_FFFF;
      fwd_vals[1]       = 32'h0000_0000;
      fwd_vals[TOTAL-1] = 32'h8000_0000;
      run_pass(0, 1'b0, -1, -1);
      chk("dir_gout0", got[0], 32'd0);
      chk("dir_gout1", got[1], 32'd2);
      chk("dir_gout1566", got[1566], 32'd1567);
      chk("dir_gout1567", got[1567], 32'd0);

      // directed backpressure, back-to-back after done
      fill_random(1'b0, 1'b0);
      run_pass(1, 1'b0, -1, -1);

      // gaps on forward stream while grad_valid held high
      fill_random(1'b0, 1'b0);
      run_pass(2, 1'b1, -1, -1);

      // clear mid-backward
      fill_random(1'b0, 1'b0);
      run_pass(2, 1'b0, 700, -1);

      // all-negative capture: everything masked
      fill_random(1'b1, 1'b1);
      fwd_vals[5] = 32'h8000_0000;
      run_pass(0, 1'b0, -1, -1);
      nz = 0;
      for (int i = 0; i < TOTAL; i++) if (got[i] != 0) nz++;
      chk("neg_nonzero_outputs", nz, 32'd0);

      // async reset mid-capture, then full passes from index 0
      fill_random(1'b0, 1'b0);
      run_pass(0, 1'b0, -1, 300);
      fill_random(1'b0, 1'b0);
      run_pass(2, 1'b0, -1, -1);
      fill_random(1'b0, 1'b0);
      run_pass(0, 1'b1, -1, -1);

      @(posedge clk); #1;
      fwd_valid = 1'b0; grad_valid = 1'b0;
      @(negedge clk);
      chk("final_done", {31'b0, done}, {31'b0, done_exp});
      chk("final_mask_ready", {31'b0, mask_ready}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
